row_feeder: RTL
===============

# row_feeder

West-edge feeder for one `mac_row`: buffers incoming operand words in a small FIFO and transmits them onto the row's `in_w`/`inst_w` inputs as either kernel-load (`inst_w=2'b01`) or execute (`inst_w=2'b10`) streams. It is command driven and transmits a fixed word count per command. After the last word it drains the row for `col` idle cycles, so that the word has propagated through every tile before completion is signalled. One instance sits at the west end of each array row, between the L0/SRAM side and the row.

## Interface

Parameters:
- `bw`, 4: operand width; matches the row's `in_w` width.
- `col`, 8: number of tiles in the driven row; sets the flush length.
- `depth`, 16: FIFO entries; must be a power of 2, minimum 2.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `wr_en`  input  1  FIFO write strobe.
- `wr_data`  input  bw  FIFO write data.
- `full`  output  1  FIFO holds `depth` entries.
- `fifo_cnt`  output  $clog2(depth)+1  current FIFO occupancy.
- `cmd_valid`  input  1  command request.
- `cmd_ready`  output  1  high exactly when the FSM is in IDLE.
- `cmd_op`  input  1  0 = kernel load, 1 = execute.
- `cmd_len`  input  8  number of words to transmit (0..255).
- `out_w`  output  bw  to the row's `in_w`; registered.
- `out_inst`  output  2  to the row's `inst_w`; registered.
- `busy`  output  1  FSM is not in IDLE.
- `done`  output  1  one-cycle completion pulse; registered.

## Operation

- FSM states: IDLE, SEND, FLUSH.
- **IDLE:** command accepted when `cmd_valid && cmd_ready`. On acceptance, latch `cmd_op`, set `remaining=cmd_len`, and go to SEND (or to FLUSH if `cmd_len==0`).
- **SEND:** pop the FIFO when it is non-empty and `remaining>0`.
  - On a pop, in the next cycle `out_w` = popped word and `out_inst` = 01 (load) or 10 (execute).
  - With no pop (FIFO empty), in the next cycle `out_inst`=00 and `out_w`=0. This bubble is legal and does not consume from `remaining`.
  - The pop that takes `remaining` to 0 moves the FSM to FLUSH.
- **FLUSH:** `out_inst`=00 and `out_w`=0 for `col` cycles, then return to IDLE with `done`=1 for that first IDLE cycle.
- `cmd_valid` is ignored while `busy`. Commands are not queued.
- **FIFO:** circular buffer with wrapping read and write pointers and an occupancy counter.
  - A write while `full` is dropped, even if a pop occurs in the same cycle. Occupancy is unchanged by the dropped write.
  - Simultaneous write and pop when not full: occupancy unchanged, both take effect.
  - No bypass. A word written into an empty FIFO is poppable from the next cycle.
- FIFO writes are accepted in every state, including during FLUSH and IDLE.
- **Reset (asynchronous, any state):**
  - FSM goes to IDLE and the FIFO is emptied.
  - `out_w`=0, `out_inst`=00, `done`=0, `full`=0, `fifo_cnt`=0, `busy`=0.
  - `cmd_ready`=1 after reset.
  - An in-flight command is aborted with no `done`.

## Timing

- Command accepted at cycle 0 means SEND starts at cycle 1. The earliest word appears on `out_w`/`out_inst` at cycle 2.
- Pop to output latency: 1 cycle.
- With no starvation and `cmd_len=N`, words appear on cycles 2..N+1 with no gaps.
- `done` is asserted exactly `col` cycles after the cycle in which the last word was presented. For `cmd_len=N` with no starvation, that is cycle N+1+`col`. For `N=0`, `done` is at cycle 1+`col`, with no 01/10 cycles at all.
- `cmd_ready` is high in the `done` cycle. A new command may be accepted in that same cycle.
- `full` and `fifo_cnt` reflect registered occupancy, updated on the edge after the write or pop.

## Test plan

- **Reset:** hold `reset`=0 mid-SEND → `out_inst`=00, `out_w`=0, `fifo_cnt`=0, `busy`=0, `cmd_ready`=1 immediately. After release, no `done` and the FIFO is empty.
- **Kernel load** (col=8): write 1..8, then command op=0 len=8 at cycle 0 → `out_inst`=01 with `out_w`=1..8 on cycles 2..9, then 00 on cycles 10..17, and `done`=1 on cycle 17 only.
- **Starved execute:** write 5,6, then command op=1 len=4 at cycle 0; write 7,8 at cycle 4 → `out_inst`=10 with 5,6 on cycles 2,3. Then 00 bubbles until 7,8 appear on cycles 6,7. `done` on cycle 7+`col`.
- **Full:** 17 consecutive writes to an idle feeder (depth 16) → `full`=1 and `fifo_cnt`=16. The 17th word is never transmitted; a following len-16 command emits exactly words 1..16 in order.
- **Wrap-around:** interleave writes and pops across more than `depth` total words → output order equals write order with no loss or duplication.
- **Zero length and back-to-back:**
  - Command len=0 → no 01/10 cycle, `done` at cycle 1+`col`.
  - A second command issued in the `done` cycle is accepted at that cycle.
  - Any `cmd_valid` while `busy` is ignored.

Source files
------------

// File: rtl/row_feeder_if.sv
// Signal bundle between the L0/SRAM side and one row_feeder:
// FIFO write port, command handshake and the row-facing operand/instruction outputs.
interface row_feeder_if #(
    parameter int bw    = 4,
    parameter int depth = 16
);
    logic                   wr_en;
    logic [bw-1:0]          wr_data;
    logic                   full;
    logic [$clog2(depth):0] fifo_cnt;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_op;
    logic [7:0]             cmd_len;
    logic [bw-1:0]          out_w;
    logic [1:0]             out_inst;
    logic                   busy;
    logic                   done;

    modport master (
        output wr_en, wr_data, cmd_valid, cmd_op, cmd_len,
        input  full, fifo_cnt, cmd_ready, out_w, out_inst, busy, done
    );

    modport slave (
        input  wr_en, wr_data, cmd_valid, cmd_op, cmd_len,
        output full, fifo_cnt, cmd_ready, out_w, out_inst, busy, done
    );
endinterface

// File: rtl/row_feeder.sv
// West-edge row feeder: FIFO-buffers operand words and streams a commanded count of them
// into a mac_row as kernel-load or execute traffic, then flushes the row before signalling done.
module row_feeder #(
    parameter int bw    = 4,
    parameter int col   = 8,
    parameter int depth = 16
) (
    input logic         clk,
    input logic         reset,
    row_feeder_if.slave bus
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam int FW = (col > 1) ? $clog2(col) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FLUSH
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [bw-1:0]  r_mem [depth];
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_cnt;

    logic [7:0]     r_remaining;
    logic           r_op;
    logic [FW-1:0]  r_flush_cnt;

    logic [bw-1:0]  r_out_w;
    logic [1:0]     r_out_inst;
    logic           r_done;

    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_accept;
    logic           w_flush_last;

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign w_full  = (r_cnt == CW'(depth));
    assign w_empty = (r_cnt == '0);
    assign w_push  = bus.wr_en && !w_full;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_pop        = 1'b0;
        w_flush_last = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = (bus.cmd_len == 8'd0) ? FLUSH : SEND;
                end
            end
            SEND: begin
                if (!w_empty && (r_remaining != 8'd0)) begin
                    w_pop = 1'b1;
                    if (r_remaining == 8'd1) begin
                        w_next_state = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (r_flush_cnt == FW'(col - 1)) begin
                    w_flush_last = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_remaining <= '0;
            r_op        <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_remaining <= bus.cmd_len;
                r_op        <= bus.cmd_op;
            end else if (w_pop) begin
                r_remaining <= r_remaining - 8'd1;
            end
            if (r_state == FLUSH) begin
                r_flush_cnt <= r_flush_cnt + FW'(1);
            end else begin
                r_flush_cnt <= '0;
            end
        end
    end

    // Storage has no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_w    <= '0;
            r_out_inst <= 2'b00;
            r_done     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out_w    <= r_mem[r_rd_ptr];
                r_out_inst <= r_op ? 2'b10 : 2'b01;
            end else begin
                r_out_w    <= '0;
                r_out_inst <= 2'b00;
            end
            r_done <= w_flush_last;
        end
    end

    assign bus.full      = w_full;
    assign bus.fifo_cnt  = r_cnt;
    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_w     = r_out_w;
    assign bus.out_inst  = r_out_inst;
    assign bus.done      = r_done;
endmodule
